// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared types and constants for the direct-mapped write-through data cache:
//   state_t        controller FSM states (IDLE, REFILL, WRITE)
//   LINE_W         refill line width in bits (4 x 32-bit words)
//   WORDS_PER_LINE number of words per line
//   WORD_W         data word width
//   OFFSET_W       word-offset bits within a line
//   LINE_BASE      offset value of the first word of a line
// ----------------------------------------------------------------------------
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2
   } state_t;

   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int WORD_W         = 32;
   localparam int OFFSET_W       = 2;

   localparam logic [OFFSET_W-1:0] LINE_BASE = 2'b00;

endpackage

// File: rtl/dcache_array.sv
// ----------------------------------------------------------------------------
// dcache_array
// Valid / tag / data storage for the direct-mapped data cache.
// Ports:
//   clk, rst_n                  clock; asynchronous active-low clear of valid bits
//   rd_index/rd_tag/rd_offset   combinational lookup address
//   rd_hit, rd_word             hit flag and addressed word (combinational)
//   line_we/line_index/line_tag/line_data   full-line refill write (sets valid)
//   word_we/word_index/word_offset/word_data single-word update of a cached line
// Tag and data arrays are not reset; only the valid bits are cleared.
// ----------------------------------------------------------------------------
module dcache_array
   import dcache_pkg::*;
#(
   parameter int INDEX_W = 5,
   parameter int TAG_W   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  rd_index,
   input  logic [TAG_W-1:0]    rd_tag,
   input  logic [OFFSET_W-1:0] rd_offset,
   output logic                rd_hit,
   output logic [WORD_W-1:0]   rd_word,
   input  logic                line_we,
   input  logic [INDEX_W-1:0]  line_index,
   input  logic [TAG_W-1:0]    line_tag,
   input  logic [LINE_W-1:0]   line_data,
   input  logic                word_we,
   input  logic [INDEX_W-1:0]  word_index,
   input  logic [OFFSET_W-1:0] word_offset,
   input  logic [WORD_W-1:0]   word_data
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0]  valid_reg;
   logic [TAG_W-1:0]  tag_mem [LINES];
   logic [WORD_W-1:0] word_rd [WORDS_PER_LINE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
      end else if (line_we) begin
         valid_reg[line_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[line_index] <= line_tag;
      end
   end

   // One word-wide bank per line position so a store can update a single word
   // while a refill writes all banks at once.
   generate
      for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
         logic [WORD_W-1:0] data_mem [LINES];

         always_ff @(posedge clk) begin
            if (line_we) begin
               data_mem[line_index] <= line_data[gi*WORD_W +: WORD_W];
            end else if (word_we && (word_offset == OFFSET_W'(gi))) begin
               data_mem[word_index] <= word_data;
            end
         end

         assign word_rd[gi] = data_mem[rd_index];
      end
   endgenerate

   assign rd_hit  = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
   assign rd_word = word_rd[rd_offset];

endmodule

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data-cache controller between
// the core load/store port and a 4-word-line data memory.
// Ports:
//   clk, RST         clock; asynchronous active-low reset
//   cpu_rd, cpu_wr   load / store request (store wins when both are set)
//   cpu_addr         word address; cpu_wdata store data
//   cpu_rdata        load data, valid when cpu_rd=1 and stall=0
//   stall            core must hold its request
//   mem_rd_en        line read request; mem_miss pulses in its first cycle
//   mem_wr_en        single-word write request
//   mem_addr/mem_wdata  memory address / write data
//   mem_rdata        refill line {w3,w2,w1,w0}; mem_ready completion
// Optional feature: define DCACHE_STATS_EN to add the 32-bit wrapping
// counters hit_cnt, miss_cnt and wr_cnt.
// ----------------------------------------------------------------------------
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int INDEX_W = 5
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic              mem_rd_en,
   output logic              mem_miss,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
   output logic [31:0]       wr_cnt
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic              first_reg, first_next;

   logic [ADDR_W-1:0] lookup_addr;
   logic              hit;
   logic [31:0]       hit_word;
   logic              line_we;
   logic              word_we;
   logic              stall_raw;
   logic [31:0]       rdata_raw;

   // In IDLE the array is looked up with the live core address; while busy it
   // looks up the latched address so a store can tell whether its line is cached.
   assign lookup_addr = (state_reg == IDLE) ? cpu_addr : addr_reg;

   assign line_we = (state_reg == REFILL) && mem_ready;
   assign word_we = (state_reg == WRITE) && mem_ready && hit;

   dcache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk         (clk),
      .rst_n       (RST),
      .rd_index    (lookup_addr[INDEX_W+OFFSET_W-1:OFFSET_W]),
      .rd_tag      (lookup_addr[ADDR_W-1:INDEX_W+OFFSET_W]),
      .rd_offset   (lookup_addr[OFFSET_W-1:0]),
      .rd_hit      (hit),
      .rd_word     (hit_word),
      .line_we     (line_we),
      .line_index  (addr_reg[INDEX_W+OFFSET_W-1:OFFSET_W]),
      .line_tag    (addr_reg[ADDR_W-1:INDEX_W+OFFSET_W]),
      .line_data   (mem_rdata),
      .word_we     (word_we),
      .word_index  (addr_reg[INDEX_W+OFFSET_W-1:OFFSET_W]),
      .word_offset (addr_reg[OFFSET_W-1:0]),
      .word_data   (wdata_reg)
   );

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         first_reg <= first_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      first_next = 1'b0;
      stall_raw  = 1'b0;
      rdata_raw  = '0;
      mem_rd_en  = 1'b0;
      mem_miss   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state_reg)
         IDLE: begin
            if (cpu_wr) begin
               stall_raw  = 1'b1;
               addr_next  = cpu_addr;
               wdata_next = cpu_wdata;
               state_next = WRITE;
            end else if (cpu_rd) begin
               if (hit) begin
                  rdata_raw = hit_word;
               end else begin
                  stall_raw  = 1'b1;
                  addr_next  = cpu_addr;
                  first_next = 1'b1;
                  state_next = REFILL;
               end
            end
         end
         REFILL: begin
            stall_raw = 1'b1;
            mem_rd_en = 1'b1;
            mem_miss  = first_reg;
            mem_addr  = {addr_reg[ADDR_W-1:OFFSET_W], LINE_BASE};
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         WRITE: begin
            stall_raw = 1'b1;
            mem_wr_en = 1'b1;
            mem_addr  = addr_reg;
            mem_wdata = wdata_reg;
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The IDLE-state outputs depend on live core inputs, so they are forced low
   // while reset is asserted to keep every output at zero during reset.
   assign stall     = RST & stall_raw;
   assign cpu_rdata = RST ? rdata_raw : '0;

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wr_cnt   <= '0;
      end else begin
         if ((state_reg == IDLE) && !cpu_wr && cpu_rd && hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (line_we) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
         if ((state_reg == WRITE) && mem_ready) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_ctrl
// Directed self-checking bench for dcache_ctrl. The bench plays the memory
// side itself (mem_ready / mem_rdata) with hand-computed lines and words.
// ----------------------------------------------------------------------------
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         RST = 1'b0;
   logic         cpu_rd = 1'b0;
   logic         cpu_wr = 1'b0;
   logic [9:0]   cpu_addr = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         stall;
   logic         mem_rd_en;
   logic         mem_miss;
   logic         mem_wr_en;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
   logic [31:0]  wr_cnt;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] L1  = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
   localparam logic [127:0] L1B = {32'h0000DDDD, 32'h0000CCCC, 32'hDEADBEEF, 32'h0000AAAA};
   localparam logic [127:0] L2  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678};
   localparam logic [127:0] L3  = {32'h84840003, 32'h84840002, 32'h84840001, 32'h84840000};

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk       (clk),
      .RST       (RST),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_rd_en (mem_rd_en),
      .mem_miss  (mem_miss),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
      .wr_cnt    (wr_cnt)
`endif
   );

   // Read that must miss: checks request cycle, REFILL cycles, then the hit.
   task automatic read_miss(input logic [9:0] a, input logic [127:0] line,
                            input logic [31:0] exp, input int n_wait, input string nm);
      logic [9:0] base;
      base = {a[9:2], 2'b00};
      cpu_rd = 1'b1;
      cpu_addr = a;
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b1000) begin
         errors++;
         $display("FAIL %s_req: stall/rd/miss/wr=%b want 1000", nm, {stall, mem_rd_en, mem_miss, mem_wr_en});
      end
      @(posedge clk); #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b1110 || mem_addr !== base) begin
         errors++;
         $display("FAIL %s_refill1: flags=%b addr=%h want 1110 addr=%h", nm,
                  {stall, mem_rd_en, mem_miss, mem_wr_en}, mem_addr, base);
      end
      for (int i = 1; i < n_wait; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b1100 || mem_addr !== base) begin
            errors++;
            $display("FAIL %s_refill_wait: flags=%b addr=%h want 1100 addr=%h", nm,
                     {stall, mem_rd_en, mem_miss, mem_wr_en}, mem_addr, base);
         end
      end
      mem_ready = 1'b1;
      mem_rdata = line;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000 || cpu_rdata !== exp) begin
         errors++;
         $display("FAIL %s_hit_after_refill: flags=%b rdata=%h want 0000 rdata=%h", nm,
                  {stall, mem_rd_en, mem_miss, mem_wr_en}, cpu_rdata, exp);
      end
      $display("read miss %s addr=%h rdata=%h", nm, a, cpu_rdata);
      @(posedge clk); #1;
      cpu_rd = 1'b0;
   endtask

   task automatic read_hit(input logic [9:0] a, input logic [31:0] exp, input string nm);
      cpu_rd = 1'b1;
      cpu_addr = a;
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000 || cpu_rdata !== exp) begin
         errors++;
         $display("FAIL %s_hit: flags=%b rdata=%h want 0000 rdata=%h", nm,
                  {stall, mem_rd_en, mem_miss, mem_wr_en}, cpu_rdata, exp);
      end
      $display("read hit %s addr=%h rdata=%h", nm, a, cpu_rdata);
      @(posedge clk); #1;
      cpu_rd = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                           input int n_wait, input string nm);
      cpu_wr = 1'b1;
      cpu_addr = a;
      cpu_wdata = d;
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b1000) begin
         errors++;
         $display("FAIL %s_req: flags=%b want 1000", nm, {stall, mem_rd_en, mem_miss, mem_wr_en});
      end
      for (int i = 0; i < n_wait; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b1001 || mem_addr !== a || mem_wdata !== d) begin
            errors++;
            $display("FAIL %s_write: flags=%b addr=%h data=%h want 1001 addr=%h data=%h", nm,
                     {stall, mem_rd_en, mem_miss, mem_wr_en}, mem_addr, mem_wdata, a, d);
         end
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      cpu_wr = 1'b0;
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000 || mem_addr !== 10'h000) begin
         errors++;
         $display("FAIL %s_done: flags=%b addr=%h want 0000 addr=000", nm,
                  {stall, mem_rd_en, mem_miss, mem_wr_en}, mem_addr);
      end
      $display("write %s addr=%h data=%h", nm, a, d);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      cpu_rd = 1'b1;
      cpu_wr = 1'b1;
      cpu_addr = 10'h004;
      cpu_wdata = 32'hFFFFFFFF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000", {stall, mem_rd_en, mem_miss, mem_wr_en});
      end
      checks++;
      if (mem_addr !== 10'h000 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, cpu_rdata);
      end
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0", hit_cnt, miss_cnt, wr_cnt);
      end
`endif
      $display("reset asserted, outputs checked");
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      @(negedge clk);
      RST = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read_miss();
      read_miss(10'h004, L1, 32'h0000AAAA, 3, "miss_004");
   endtask

   task automatic test_read_hit();
      read_hit(10'h006, 32'h0000CCCC, "hit_006");
      read_hit(10'h007, 32'h0000DDDD, "hit_007");
   endtask

   task automatic test_write_hit();
      do_write(10'h005, 32'hDEADBEEF, 1, "wr_005");
      read_hit(10'h005, 32'hDEADBEEF, "hit_005");
      read_hit(10'h004, 32'h0000AAAA, "hit_004");
   endtask

   task automatic test_write_miss();
      do_write(10'h200, 32'h12345678, 2, "wr_200");
      read_miss(10'h200, L2, 32'h12345678, 2, "miss_200");
      read_hit(10'h203, 32'h44444444, "hit_203");
   endtask

   task automatic test_conflict();
      read_miss(10'h084, L3, 32'h84840000, 1, "miss_084");
      read_miss(10'h004, L1B, 32'h0000AAAA, 2, "remiss_004");
      read_hit(10'h005, 32'hDEADBEEF, "hit_005b");
   endtask

   task automatic test_ready_in_idle();
      mem_ready = 1'b1;
      mem_rdata = {128{1'b1}};
      @(posedge clk); #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_ready: flags=%b want 0000", {stall, mem_rd_en, mem_miss, mem_wr_en});
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      read_hit(10'h004, 32'h0000AAAA, "hit_after_idle_ready");
   endtask

   task automatic test_stats_before_reset();
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_cnt !== 32'd11 || miss_cnt !== 32'd4 || wr_cnt !== 32'd2) begin
         errors++;
         $display("FAIL stats_pre: hit=%0d miss=%0d wr=%0d want 11 4 2", hit_cnt, miss_cnt, wr_cnt);
      end
      $display("stats hit=%0d miss=%0d wr=%0d", hit_cnt, miss_cnt, wr_cnt);
`endif
   endtask

   task automatic test_reset_mid_refill();
      cpu_rd = 1'b1;
      cpu_addr = 10'h008;
      @(posedge clk); #1;
      checks++;
      if (mem_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL midrst_refill: mem_rd_en=%b want 1", mem_rd_en);
      end
      #2;
      RST = 1'b0;
      #1;
      checks++;
      if ({stall, mem_rd_en, mem_miss, mem_wr_en} !== 4'b0000 || mem_addr !== 10'h000 ||
          mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_outputs: flags=%b addr=%h wdata=%h rdata=%h want all 0",
                  {stall, mem_rd_en, mem_miss, mem_wr_en}, mem_addr, mem_wdata, cpu_rdata);
      end
      $display("reset asserted mid-refill");
      cpu_rd = 1'b0;
      @(negedge clk);
      RST = 1'b1;
      @(posedge clk); #1;
      read_miss(10'h004, L1B, 32'h0000AAAA, 2, "post_reset_004");
      do_write(10'h005, 32'hCAFEF00D, 2, "wr_005b");
   endtask

   task automatic test_back_to_back();
      cpu_rd = 1'b1;
      cpu_addr = 10'h004;
      #1;
      checks++;
      if (stall !== 1'b0 || cpu_rdata !== 32'h0000AAAA) begin
         errors++;
         $display("FAIL b2b_first: stall=%b rdata=%h want 0 0000aaaa", stall, cpu_rdata);
      end
      @(posedge clk); #1;
      cpu_addr = 10'h005;
      #1;
      checks++;
      if (stall !== 1'b0 || cpu_rdata !== 32'hCAFEF00D || mem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: stall=%b rdata=%h rd_en=%b want 0 cafef00d 0", stall, cpu_rdata, mem_rd_en);
      end
      $display("back-to-back hits 004 then 005 rdata=%h", cpu_rdata);
      @(posedge clk); #1;
      cpu_rd = 1'b0;
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1 || wr_cnt !== 32'd1) begin
         errors++;
         $display("FAIL stats_final: hit=%0d miss=%0d wr=%0d want 3 1 1", hit_cnt, miss_cnt, wr_cnt);
      end
      $display("stats hit=%0d miss=%0d wr=%0d", hit_cnt, miss_cnt, wr_cnt);
`endif
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_ready_in_idle();
      test_stats_before_reset();
      test_reset_mid_refill();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
